// File: rtl/csa_pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : csa_pipe_adder
// Brief  : Pipelined conditional-sum adder/subtractor, one SEG-bit segment per stage
// Rev    : 1.0
// ============================================================================
module csa_pipe_adder #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int STAGES = (WIDTH + SEG - 1) / SEG;

  logic                         stall;
  logic                         cin_eff;
  logic                         ovf_q;
  logic [STAGES-1:0]            stg_vld;
  logic [STAGES-1:0]            stg_cy;
  logic [STAGES-1:0][WIDTH-1:0] stg_res;
  // Operands entering stage i; stage 0 takes them straight from the ports.
  logic [STAGES-1:0][WIDTH-1:0] stg_opa;
  logic [STAGES-1:0][WIDTH-1:0] stg_opb;

  assign stall      = stg_vld[STAGES-1] & ~out_ready;
  assign in_ready   = ~stall;
  assign cin_eff    = sub | ci;
  assign stg_opa[0] = a;
  assign stg_opb[0] = sub ? ~b : b;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int LO = i * SEG;
    localparam int SW = (i == STAGES - 1) ? (WIDTH - LO) : SEG;

    logic             vld_in, cy_in, cy_d;
    logic [WIDTH-1:0] res_in, res_d;
    logic [SW-1:0]    seg_a, seg_b;
    logic [SW:0]      sum0, sum1;
    logic             vld_q, cy_q;
    logic [WIDTH-1:0] res_q;

    if (i == 0) begin : g_head
      assign vld_in = in_valid;
      assign cy_in  = cin_eff;
      assign res_in = '0;
    end else begin : g_body
      assign vld_in = stg_vld[i-1];
      assign cy_in  = stg_cy[i-1];
      assign res_in = stg_res[i-1];
    end

    assign seg_a = SW'(stg_opa[i] >> LO);
    assign seg_b = SW'(stg_opb[i] >> LO);
    assign sum0  = {1'b0, seg_a} + {1'b0, seg_b};
    assign sum1  = {1'b0, seg_a} + {1'b0, seg_b} + (SW + 1)'(1);

    always_comb begin
      res_d            = res_in;
      res_d[LO +: SW]  = cy_in ? sum1[SW-1:0] : sum0[SW-1:0];
      cy_d             = cy_in ? sum1[SW] : sum0[SW];
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        res_q <= '0;
      end else if (!stall) begin
        vld_q <= vld_in;
        cy_q  <= cy_d;
        res_q <= res_d;
      end
    end

    assign stg_vld[i] = vld_q;
    assign stg_cy[i]  = cy_q;
    assign stg_res[i] = res_q;

    if (i < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] opa_q, opb_q;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (!stall) begin
          opa_q <= stg_opa[i];
          opb_q <= stg_opb[i];
        end
      end

      assign stg_opa[i+1] = opa_q;
      assign stg_opb[i+1] = opb_q;
    end else begin : g_last
      // Overflow is resolved alongside the top segment, where both operand MSBs are still at hand.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= (stg_opa[i][WIDTH-1] == stg_opb[i][WIDTH-1]) &&
                   (res_d[WIDTH-1] != stg_opa[i][WIDTH-1]);
        end
      end
    end
  end

  assign out_valid = stg_vld[STAGES-1];
  assign sum       = stg_res[STAGES-1];
  assign co        = stg_cy[STAGES-1];
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for csa_pipe_adder: three configurations (3/1, 8/4, 10/4) checked against a signed/unsigned arithmetic model.
module tb_csa_pipe_adder;

  localparam int NI = 3;

  typedef struct {
    int exp;
    int acc;
    int stl;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv   [NI];
  logic       cin  [NI];
  logic       sb   [NI];
  logic       ordy [NI];
  logic       irdy [NI];
  logic       ovd  [NI];
  logic       cow  [NI];
  logic       ovfw [NI];
  int         opa  [NI];
  int         opb  [NI];
  logic [2:0] s0;
  logic [7:0] s1;
  logic [9:0] s2;

  ent_t q0[$], q1[$], q2[$];
  int   log_q[$];
  bit   log_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   stall_cnt  [NI];
  int   pop_cnt    [NI];
  int   prev_out   [NI];
  bit   prev_stall [NI];
  bit   rst_chk    [NI];
  bit   rnd_done = 1'b0;

  always #5 clk = ~clk;

  csa_pipe_adder #(.WIDTH(3), .SEG(1)) u_w3 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(3'(opa[0])), .b(3'(opb[0])), .ci(cin[0]), .sub(sb[0]),
    .out_valid(ovd[0]), .out_ready(ordy[0]), .sum(s0), .co(cow[0]), .ovf(ovfw[0]));

  csa_pipe_adder #(.WIDTH(8), .SEG(4)) u_w8 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(8'(opa[1])), .b(8'(opb[1])), .ci(cin[1]), .sub(sb[1]),
    .out_valid(ovd[1]), .out_ready(ordy[1]), .sum(s1), .co(cow[1]), .ovf(ovfw[1]));

  csa_pipe_adder #(.WIDTH(10), .SEG(4)) u_w10 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(10'(opa[2])), .b(10'(opb[2])), .ci(cin[2]), .sub(sb[2]),
    .out_valid(ovd[2]), .out_ready(ordy[2]), .sum(s2), .co(cow[2]), .ovf(ovfw[2]));

  function automatic int wd(int id);
    return (id == 0) ? 3 : (id == 1) ? 8 : 10;
  endfunction

  function automatic int lat(int id);
    return (id == 1) ? 2 : 3;
  endfunction

  // Reference: {ovf, co, sum} from plain integer arithmetic on the operand values.
  function automatic int model(int w, int a, int b, bit c, bit s);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint sa   = (a >= half) ? a - (m + 1) : a;
    longint sbv  = (b >= half) ? b - (m + 1) : b;
    longint r, sr;
    bit     ov;
    if (s) begin
      r  = a + (m - b) + 1;
      sr = sa - sbv;
    end else begin
      r  = a + b + c;
      sr = sa + sbv + c;
    end
    ov = (sr >= half) || (sr < -half);
    return int'((longint'(ov) << (w + 1)) | (((r >> w) & 1) << w) | (r & m));
  endfunction

  function automatic int out_word(int id);
    case (id)
      0:       return (int'(ovfw[0]) << 4)  | (int'(cow[0]) << 3)  | int'(s0);
      1:       return (int'(ovfw[1]) << 9)  | (int'(cow[1]) << 8)  | int'(s1);
      default: return (int'(ovfw[2]) << 11) | (int'(cow[2]) << 10) | int'(s2);
    endcase
  endfunction

  function automatic int q_size(int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(int id, ent_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(int id, output ent_t e);
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic q_clear(int id);
    case (id)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon_step(int id);
    int   w    = wd(id);
    int   word = out_word(id);
    int   full = (int'(ovd[id]) << (w + 2)) | word;
    bit   st;
    ent_t e;
    if (!rst_n) begin
      q_clear(id);
      rst_chk[id]    = 1'b1;
      prev_stall[id] = 1'b0;
      return;
    end
    if (rst_chk[id]) begin
      check($sformatf("reset_state[%0d]", id), full, 0);
      rst_chk[id] = 1'b0;
    end
    st = ovd[id] && !ordy[id];
    check($sformatf("in_ready[%0d]", id), int'(irdy[id]), int'(!st));
    if (prev_stall[id])
      check($sformatf("stall_hold[%0d]", id), full, prev_out[id]);
    if (ovd[id] && ordy[id]) begin
      check($sformatf("beat_expected[%0d]", id), int'(q_size(id) > 0), 1);
      if (q_size(id) > 0) begin
        q_pop(id, e);
        pop_cnt[id]++;
        check($sformatf("result[%0d]", id), word, e.exp);
        check($sformatf("latency[%0d]", id), cyc - e.acc, lat(id) + stall_cnt[id] - e.stl);
        if (id == 1 && log_en) log_q.push_back(word & 'hFF);
      end
    end
    if (iv[id] && irdy[id]) begin
      e.exp = model(w, opa[id], opb[id], cin[id], sb[id]);
      e.acc = cyc;
      e.stl = stall_cnt[id];
      q_push(id, e);
    end
    if (st) stall_cnt[id]++;
    prev_stall[id] = st;
    prev_out[id]   = full;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int id = 0; id < NI; id++) mon_step(id);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
  task automatic send(int id, int a, int b, bit c, bit s);
    int n = 0;
    iv[id] = 1'b1; opa[id] = a; opb[id] = b; cin[id] = c; sb[id] = s;
    @(negedge clk);
    while (!irdy[id] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!irdy[id]) check($sformatf("send_wait[%0d]", id), int'(irdy[id]), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int id);
    int n = 0;
    while ((q_size(id) != 0 || ovd[id]) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("drain[%0d]", id), q_size(id), 0);
  endtask

  task automatic lit8(int a, int b, bit c, bit s, int es, int ec, int eo);
    send(1, a, b, c, s);
    iv[1] = 1'b0;
    check("lit_early_valid", int'(ovd[1]), 0);
    @(posedge clk);
    #1;
    check("lit_valid", int'(ovd[1]), 1);
    check("lit_sum", int'(s1), es);
    check("lit_co", int'(cow[1]), ec);
    check("lit_ovf", int'(ovfw[1]), eo);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; cin[i] = 1'b0; sb[i] = 1'b0; ordy[i] = 1'b1;
      opa[i] = 0; opb[i] = 0;
      stall_cnt[i] = 0; pop_cnt[i] = 0; prev_out[i] = 0;
      prev_stall[i] = 1'b0; rst_chk[i] = 1'b0;
    end
    check("pin_add_wrap",  model(8, 'hFF, 'h01, 1'b0, 1'b0), 'h100);
    check("pin_sub_ovf",   model(8, 'h80, 'h01, 1'b0, 1'b1), 'h37F);
    check("pin_sub_borrow", model(8, 'h05, 'h07, 1'b0, 1'b1), 'h0FE);
    check("pin_w3_cin",    model(3, 7, 7, 1'b1, 1'b0), 'h00F);
    check("pin_w10_ovf",   model(10, 'h1FF, 1, 1'b0, 1'b0), 'hA00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_out_valid", int'(ovd[1]), 0);
    check("reset_sum", int'(s1), 0);

    // Exhaustive 3-bit add, back to back.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          send(0, a, b, 1'(c), 1'b0);
    iv[0] = 1'b0;
    drain(0);
    check("w3_beats", pop_cnt[0], 128);

    lit8('hFF, 'h01, 1'b0, 1'b0, 'h00, 1, 0);
    lit8('h80, 'h01, 1'b0, 1'b1, 'h7F, 1, 1);
    lit8('h05, 'h07, 1'b0, 1'b1, 'hFE, 0, 0);
    lit8('h05, 'h07, 1'b1, 1'b1, 'hFE, 0, 0);
    lit8('h7F, 'h00, 1'b1, 1'b0, 'h80, 0, 1);
    drain(1);

    // Backpressure mid-stream.
    log_q.delete();
    log_en = 1'b1;
    fork
      begin
        for (int k = 1; k <= 6; k++) send(1, k, 1, 1'b0, 1'b0);
        iv[1] = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 ordy[1] = 1'b0;
        #1 check("bp_in_ready_low", int'(irdy[1]), 0);
        repeat (3) @(posedge clk);
        #1 ordy[1] = 1'b1;
      end
    join
    drain(1);
    check("bp_count", log_q.size(), 6);
    for (int k = 0; k < 6 && k < log_q.size(); k++)
      check($sformatf("bp_order%0d", k), log_q[k], k + 2);

    // Reset with two beats in flight.
    log_q.delete();
    send(1, 10, 20, 1'b0, 1'b0);
    send(1, 30, 40, 1'b0, 1'b0);
    iv[1] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_valid", int'(ovd[1]), 0);
    check("midrst_sum", int'(s1), 0);
    repeat (5) @(posedge clk);
    #1;
    send(1, 3, 4, 1'b1, 1'b0);
    iv[1] = 1'b0;
    drain(1);
    log_en = 1'b0;
    check("postrst_count", log_q.size(), 1);
    if (log_q.size() > 0) check("postrst_sum", log_q[0], 8);

    // Random stream with random backpressure on the 3-stage, uneven-segment build.
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          if ($urandom_range(3) == 0) begin
            iv[2] = 1'b0;
            @(posedge clk);
            #1;
          end
          send(2, int'($urandom_range(1023)), int'($urandom_range(1023)),
               1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        iv[2] = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          ordy[2] = ($urandom_range(3) != 0);
          @(posedge clk);
          #1;
        end
        ordy[2] = 1'b1;
      end
    join
    drain(2);
    check("rnd_beats", pop_cnt[2], 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
